// File: rtl/sudoku_board_sequencer.sv
// Sequences the 4x24-bit game-state RAM: ROM puzzle load, controller play, post-write solve scan.
// Optional build macro SUDOKU_BOX_CHECK_EN adds the 2x2 box constraint to the solved verdict.
module sudoku_board_sequencer #(
  parameter int PUZZLE_BITS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   newGame,
  input  logic [PUZZLE_BITS-1:0] puzzleSel,
  output logic [PUZZLE_BITS+1:0] RomAddr,
  input  logic [23:0]            RomDat,
  input  logic [1:0]             ctlAddr,
  input  logic                   ctlWriteBit,
  input  logic [23:0]            ctlWriteBuf,
  output logic [23:0]            ctlDat,
  output logic                   ctlReady,
  output logic [1:0]             RamAddr,
  output logic                   RamWriteBit,
  output logic [23:0]            RamWriteBuf,
  input  logic [23:0]            RamDat,
  output logic                   busy,
  output logic                   solved
);

  typedef enum logic [1:0] {LOAD, CHECK, COMMIT, USER} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [PUZZLE_BITS-1:0] puz_q, puz_d;
  logic [PUZZLE_BITS+1:0] rom_addr_q, rom_addr_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [1:0]             pend_addr_q, pend_addr_d;
  logic [23:0]            pend_dat_q, pend_dat_d;
  logic [23:0]            shadow_q, shadow_d;
  logic                   solved_q, solved_d;
  logic                   row_ok_q, row_ok_d, row_ok_nxt;
  logic [3:0][3:0]        col_q, col_d, col_nxt, col_base;
  logic [3:0]             oh0, oh1, oh2, oh3;
  logic                   all_ok;
`ifdef SUDOKU_BOX_CHECK_EN
  logic [3:0][3:0]        box_q, box_d, box_nxt, box_base;
`endif

  function automatic logic [3:0] onehot(input logic [3:0] d);
    case (d)
      4'd1:    onehot = 4'b0001;
      4'd2:    onehot = 4'b0010;
      4'd3:    onehot = 4'b0100;
      4'd4:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  endfunction

  function automatic logic row_valid(input logic [19:0] w);
    logic [3:0] m;
    m = onehot(w[3:0]) | onehot(w[7:4]) | onehot(w[11:8]) | onehot(w[15:12]);
    row_valid = (w[19:16] == 4'd0) && (m == 4'hF);
  endfunction

  // Scan datapath: accumulators restart on row 0 so no clearing cycle is needed.
  always_comb begin
    oh0        = onehot(RamDat[3:0]);
    oh1        = onehot(RamDat[7:4]);
    oh2        = onehot(RamDat[11:8]);
    oh3        = onehot(RamDat[15:12]);
    col_base   = (cnt_q == 3'd0) ? '0 : col_q;
    row_ok_nxt = ((cnt_q == 3'd0) ? 1'b1 : row_ok_q) && row_valid(RamDat[19:0]);
    col_nxt[0] = col_base[0] | oh0;
    col_nxt[1] = col_base[1] | oh1;
    col_nxt[2] = col_base[2] | oh2;
    col_nxt[3] = col_base[3] | oh3;
    all_ok     = row_ok_nxt && (col_nxt == 16'hFFFF);
`ifdef SUDOKU_BOX_CHECK_EN
    box_base   = (cnt_q == 3'd0) ? '0 : box_q;
    box_nxt[0] = box_base[0] | (cnt_q[1] ? 4'd0 : (oh0 | oh1));
    box_nxt[1] = box_base[1] | (cnt_q[1] ? 4'd0 : (oh2 | oh3));
    box_nxt[2] = box_base[2] | (cnt_q[1] ? (oh0 | oh1) : 4'd0);
    box_nxt[3] = box_base[3] | (cnt_q[1] ? (oh2 | oh3) : 4'd0);
    all_ok     = all_ok && (box_nxt == 16'hFFFF);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    puz_d       = puz_q;
    rom_addr_d  = rom_addr_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    shadow_d    = shadow_q;
    solved_d    = solved_q;
    row_ok_d    = row_ok_q;
    col_d       = col_q;
`ifdef SUDOKU_BOX_CHECK_EN
    box_d       = box_q;
`endif
    RamAddr     = 2'd0;
    RamWriteBit = 1'b0;
    RamWriteBuf = 24'd0;
    ctlDat      = shadow_q;

    case (state_q)
      LOAD: begin
        // ROM has one cycle of latency, so row k-1 is written while row k is addressed.
        if (cnt_q != 3'd0) begin
          RamAddr     = cnt_q[1:0] - 2'd1;
          RamWriteBit = 1'b1;
          RamWriteBuf = RomDat;
        end
        if (cnt_q < 3'd3) rom_addr_d = {puz_q, cnt_q[1:0] + 2'd1};
        if (cnt_q == 3'd4) begin
          state_d = CHECK;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      CHECK: begin
        RamAddr  = cnt_q[1:0];
        row_ok_d = row_ok_nxt;
        col_d    = col_nxt;
`ifdef SUDOKU_BOX_CHECK_EN
        box_d    = box_nxt;
`endif
        if (ctlWriteBit) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = ctlAddr;
          pend_dat_d  = ctlWriteBuf;
        end
        if (cnt_q == 3'd3) begin
          solved_d = all_ok;
          cnt_d    = 3'd0;
          state_d  = pend_vld_d ? COMMIT : USER;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      COMMIT: begin
        RamAddr     = pend_addr_q;
        RamWriteBit = 1'b1;
        RamWriteBuf = pend_dat_q;
        pend_vld_d  = 1'b0;
        if (ctlWriteBit) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = ctlAddr;
          pend_dat_d  = ctlWriteBuf;
        end
        state_d = CHECK;
        cnt_d   = 3'd0;
      end
      USER: begin
        RamAddr     = ctlAddr;
        RamWriteBit = ctlWriteBit;
        RamWriteBuf = ctlWriteBuf;
        ctlDat      = RamDat;
        shadow_d    = RamDat;
        if (ctlWriteBit) begin
          state_d = CHECK;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = LOAD;
    endcase

    if (newGame) begin
      state_d    = LOAD;
      cnt_d      = 3'd0;
      puz_d      = puzzleSel;
      rom_addr_d = {puzzleSel, 2'b00};
      pend_vld_d = 1'b0;
      solved_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LOAD;
      cnt_q      <= 3'd0;
      puz_q      <= '0;
      rom_addr_q <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= 24'd0;
      solved_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      puz_q      <= puz_d;
      rom_addr_q <= rom_addr_d;
      pend_vld_q <= pend_vld_d;
      shadow_q   <= shadow_d;
      solved_q   <= solved_d;
    end
  end

  always_ff @(posedge CLK) begin
    pend_addr_q <= pend_addr_d;
    pend_dat_q  <= pend_dat_d;
    row_ok_q    <= row_ok_d;
    col_q       <= col_d;
`ifdef SUDOKU_BOX_CHECK_EN
    box_q       <= box_d;
`endif
  end

  assign RomAddr  = rom_addr_q;
  assign solved   = solved_q;
  assign ctlReady = (state_q == USER);
  assign busy     = ~ctlReady;

endmodule
